// File: rtl/countdown_timer.sv
// Loadable down-counting timer with a one-cycle expiry pulse and a saturating expiry tally.
// Optional periodic mode: define COUNTDOWN_TIMER_AUTORELOAD_EN to reload the last start value on expiry.
module countdown_timer #(
  parameter int N      = 8,
  parameter int ECNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              abort,
  input  logic              load_valid,
  input  logic [N-1:0]      load_value,
  output logic              load_ready,
  output logic [N-1:0]      count_out,
  output logic              busy,
  output logic              expired,
  output logic [ECNT_W-1:0] expire_cnt
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_EXPIRE = 2'd2;

  localparam logic [N-1:0] CNT_ZERO = '0;
  localparam logic [N-1:0] CNT_ONE  = N'(1);

  logic [1:0]        state_p0;
  logic [N-1:0]      count_p0;
  logic              expired_p0;
  logic [ECNT_W-1:0] ecnt_p0;

  function automatic logic [ECNT_W-1:0] sat_inc(input logic [ECNT_W-1:0] v);
    if (&v) begin
      return v;
    end
    return v + ECNT_W'(1);
  endfunction

`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
  logic [N-1:0] reload_p0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      reload_p0 <= '0;
    end else if (state_p0 == S_IDLE && load_valid) begin
      reload_p0 <= load_value;
    end
  end
`endif

  // Stage p0: state, count, pulse and tally all settle on the same edge
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_p0   <= S_IDLE;
      count_p0   <= '0;
      expired_p0 <= 1'b0;
      ecnt_p0    <= '0;
    end else begin
      expired_p0 <= 1'b0;
      case (state_p0)
        S_IDLE: begin
          if (load_valid) begin
            count_p0 <= load_value;
            if (load_value != CNT_ZERO) begin
              state_p0 <= S_RUN;
            end else begin
              state_p0   <= S_EXPIRE;
              expired_p0 <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (abort) begin
            state_p0 <= S_IDLE;
            count_p0 <= '0;
          end else if (en) begin
            if (count_p0 == CNT_ONE) begin
              count_p0   <= '0;
              state_p0   <= S_EXPIRE;
              expired_p0 <= 1'b1;
            end else begin
              count_p0 <= count_p0 - CNT_ONE;
            end
          end
        end
        S_EXPIRE: begin
          ecnt_p0 <= sat_inc(ecnt_p0);
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
          if (!abort && reload_p0 != CNT_ZERO) begin
            count_p0 <= reload_p0;
            state_p0 <= S_RUN;
          end else begin
            state_p0 <= S_IDLE;
          end
`else
          state_p0 <= S_IDLE;
`endif
        end
        default: begin
          state_p0 <= S_IDLE;
          count_p0 <= '0;
        end
      endcase
    end
  end

  assign load_ready = (state_p0 == S_IDLE);
  assign busy       = (state_p0 != S_IDLE);
  assign count_out  = count_p0;
  assign expired    = expired_p0;
  assign expire_cnt = ecnt_p0;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer (N=8, ECNT_W=2) with hand-computed expectations.
module tb_countdown_timer;

  localparam int N      = 8;
  localparam int ECNT_W = 2;
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
  localparam logic AR = 1'b1;
`else
  localparam logic AR = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic              abort;
  logic              load_valid;
  logic [N-1:0]      load_value;
  logic              load_ready;
  logic [N-1:0]      count_out;
  logic              busy;
  logic              expired;
  logic [ECNT_W-1:0] expire_cnt;

  int vectors = 0;
  int miscompares = 0;

  countdown_timer #(.N(N), .ECNT_W(ECNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .abort      (abort),
    .load_valid (load_valid),
    .load_value (load_value),
    .load_ready (load_ready),
    .count_out  (count_out),
    .busy       (busy),
    .expired    (expired),
    .expire_cnt (expire_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [N-1:0] c, input logic e,
                         input logic [ECNT_W-1:0] ec, input logic rdy, input logic bsy);
    chk({tag, ".count"},   32'(count_out),  32'(c));
    chk({tag, ".expired"}, 32'(expired),    32'(e));
    chk({tag, ".ecnt"},    32'(expire_cnt), 32'(ec));
    chk({tag, ".ready"},   32'(load_ready), 32'(rdy));
    chk({tag, ".busy"},    32'(busy),       32'(bsy));
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; abort = 1'b0; load_valid = 1'b0; load_value = '0;
    tick();
    tick();
    chk_all("reset", 8'd0, 1'b0, 2'd0, 1'b1, 1'b0);

    // Load 5 with en held high
    rst = 1'b1; en = 1'b1; load_valid = 1'b1; load_value = 8'd5;
    tick();
    load_valid = 1'b0;
    chk_all("l5.k", 8'd5, 1'b0, 2'd0, 1'b0, 1'b1);
    tick(); chk_all("l5.4", 8'd4, 1'b0, 2'd0, 1'b0, 1'b1);
    tick(); chk_all("l5.3", 8'd3, 1'b0, 2'd0, 1'b0, 1'b1);
    tick(); chk_all("l5.2", 8'd2, 1'b0, 2'd0, 1'b0, 1'b1);
    tick(); chk_all("l5.1", 8'd1, 1'b0, 2'd0, 1'b0, 1'b1);
    tick(); chk_all("l5.exp", 8'd0, 1'b1, 2'd0, 1'b0, 1'b1);
    abort = AR;
    tick(); chk_all("l5.idle", 8'd0, 1'b0, 2'd1, 1'b1, 1'b0);
    abort = 1'b0;

    // Load 3 with en gaps; a load during RUN must be ignored
    load_valid = 1'b1; load_value = 8'd3;
    tick();
    chk_all("l3.k", 8'd3, 1'b0, 2'd1, 1'b0, 1'b1);
    load_value = 8'd9; en = 1'b1;
    tick(); chk_all("l3.e1", 8'd2, 1'b0, 2'd1, 1'b0, 1'b1);
    load_valid = 1'b0; en = 1'b0;
    tick(); chk_all("l3.g1", 8'd2, 1'b0, 2'd1, 1'b0, 1'b1);
    en = 1'b1;
    tick(); chk_all("l3.e2", 8'd1, 1'b0, 2'd1, 1'b0, 1'b1);
    en = 1'b0;
    tick(); chk_all("l3.g2", 8'd1, 1'b0, 2'd1, 1'b0, 1'b1);
    en = 1'b1;
    tick(); chk_all("l3.exp", 8'd0, 1'b1, 2'd1, 1'b0, 1'b1);
    abort = AR;
    tick(); chk_all("l3.idle", 8'd0, 1'b0, 2'd2, 1'b1, 1'b0);
    abort = 1'b0;

    // Load 10, abort after 4 decrements (abort beats en)
    load_valid = 1'b1; load_value = 8'd10;
    tick();
    load_valid = 1'b0;
    chk_all("l10.k", 8'd10, 1'b0, 2'd2, 1'b0, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("l10.dec", 32'(count_out), 32'(10 - i));
      chk("l10.noexp", 32'(expired), 32'd0);
    end
    abort = 1'b1;
    tick(); chk_all("l10.abort", 8'd0, 1'b0, 2'd2, 1'b1, 1'b0);
    abort = 1'b0; en = 1'b0;
    tick(); chk_all("l10.after", 8'd0, 1'b0, 2'd2, 1'b1, 1'b0);

    // Zero loads: immediate pulse, tally saturates at 3
    load_valid = 1'b1; load_value = 8'd0;
    tick();
    load_valid = 1'b0;
    chk_all("z1.k", 8'd0, 1'b1, 2'd2, 1'b0, 1'b1);
    tick(); chk_all("z1.idle", 8'd0, 1'b0, 2'd3, 1'b1, 1'b0);
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    chk_all("z2.k", 8'd0, 1'b1, 2'd3, 1'b0, 1'b1);
    tick(); chk_all("z2.sat", 8'd0, 1'b0, 2'd3, 1'b1, 1'b0);

    // Minimum period for L=1: load, expire, idle
    en = 1'b1; load_valid = 1'b1; load_value = 8'd1;
    tick();
    load_valid = 1'b0;
    chk_all("l1.k", 8'd1, 1'b0, 2'd3, 1'b0, 1'b1);
    tick(); chk_all("l1.exp", 8'd0, 1'b1, 2'd3, 1'b0, 1'b1);
    abort = AR;
    tick(); chk_all("l1.idle", 8'd0, 1'b0, 2'd3, 1'b1, 1'b0);
    abort = 1'b0;

`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
    // Periodic mode: load 2 expires every 3 cycles until aborted in EXPIRE
    load_valid = 1'b1; load_value = 8'd2;
    tick();
    load_valid = 1'b0;
    chk_all("ar.k", 8'd2, 1'b0, 2'd3, 1'b0, 1'b1);
    for (int r = 0; r < 2; r++) begin
      tick(); chk_all("ar.1", 8'd1, 1'b0, 2'd3, 1'b0, 1'b1);
      tick(); chk_all("ar.exp", 8'd0, 1'b1, 2'd3, 1'b0, 1'b1);
      if (r == 0) begin
        tick(); chk_all("ar.reload", 8'd2, 1'b0, 2'd3, 1'b0, 1'b1);
      end
    end
    abort = 1'b1;
    tick(); chk_all("ar.abort", 8'd0, 1'b0, 2'd3, 1'b1, 1'b0);
    abort = 1'b0;
`endif

    // Reset mid-run clears everything including the tally
    load_valid = 1'b1; load_value = 8'd7;
    tick();
    load_valid = 1'b0;
    tick(); chk("mid.count", 32'(count_out), 32'd6);
    rst = 1'b0;
    tick(); chk_all("mid.rst", 8'd0, 1'b0, 2'd0, 1'b1, 1'b0);
    rst = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
